// File: rtl/metric_div_scheduler.sv
// metric_div_scheduler: round-robin arbiter sharing one restoring divider between two requesters
// One quotient bit per cycle; a zero divisor skips the divide phase and reports div-by-zero.
module metric_div_scheduler #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_dividend,
    input  logic [WIDTH-1:0] req0_divisor,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_dividend,
    input  logic [WIDTH-1:0] req1_divisor,
    output logic             req1_ready,
    output logic             res_valid,
    output logic             res_id,
    output logic [WIDTH-1:0] res_quotient,
    output logic [WIDTH-1:0] res_remainder,
    output logic             res_div_by_zero,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;
    state_t           state;
    logic             prio;
    logic             cur_id;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic [CW-1:0]    cnt;
    logic             grant0, grant1;
    logic [WIDTH-1:0] acc_dividend, acc_divisor;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] next_rem, next_quo;
    // prio high means requester 1 wins a tie
    always_comb begin
        grant0       = rst && state == IDLE && req0_valid && (!req1_valid || !prio);
        grant1       = rst && state == IDLE && req1_valid && (!req0_valid || prio);
        acc_dividend = grant1 ? req1_dividend : req0_dividend;
        acc_divisor  = grant1 ? req1_divisor : req0_divisor;
        shifted      = {rem, quo[WIDTH-1]};
        diff         = shifted - {1'b0, dvs};
        next_rem     = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        next_quo     = {quo[WIDTH-2:0], ~diff[WIDTH]};
    end
    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign res_valid  = state == DONE;
    assign busy       = state != IDLE;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            prio            <= 1'b0;
            cur_id          <= 1'b0;
            rem             <= '0;
            quo             <= '0;
            dvs             <= '0;
            cnt             <= '0;
            res_id          <= 1'b0;
            res_quotient    <= '0;
            res_remainder   <= '0;
            res_div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (grant0 || grant1) begin
                    prio   <= ~grant1;
                    cur_id <= grant1;
                    rem    <= '0;
                    quo    <= acc_dividend;
                    dvs    <= acc_divisor;
                    cnt    <= '0;
                    if (acc_divisor == '0) begin
                        state           <= DONE;
                        res_id          <= grant1;
                        res_quotient    <= '0;
                        res_remainder   <= acc_dividend;
                        res_div_by_zero <= 1'b1;
                    end else begin
                        state <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    rem <= next_rem;
                    quo <= next_quo;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state           <= DONE;
                        res_id          <= cur_id;
                        res_quotient    <= next_quo;
                        res_remainder   <= next_rem;
                        res_div_by_zero <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_metric_div_scheduler.sv
// tb_metric_div_scheduler: directed self-checking bench for the shared divider scheduler
module tb_metric_div_scheduler;
    localparam int W = 32;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0] req0_dividend = '0, req0_divisor = '0;
    logic [W-1:0] req1_dividend = '0, req1_divisor = '0;
    logic         req0_ready, req1_ready, res_valid, res_id, res_div_by_zero, busy;
    logic [W-1:0] res_quotient, res_remainder;
    int checks = 0, failures = 0, ready_bad = 0;
    int g, n, lat;

    metric_div_scheduler #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_dividend(req0_dividend), .req0_divisor(req0_divisor), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_dividend(req1_dividend), .req1_divisor(req1_divisor), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_id(res_id), .res_quotient(res_quotient), .res_remainder(res_remainder),
        .res_div_by_zero(res_div_by_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        if (id == 0) begin
            req0_valid = 1'b1; req0_dividend = a; req0_divisor = b;
        end else begin
            req1_valid = 1'b1; req1_dividend = a; req1_divisor = b;
        end
    endtask

    task automatic wait_grant(input string tag, output int id, output int waited);
        waited = 0;
        #1;
        while (!req0_ready && !req1_ready && waited < 8) begin
            @(negedge clk); #1; waited++;
        end
        chk({tag, "_one_ready"}, 32'(req0_ready & req1_ready), 0);
        id = req1_ready ? 1 : req0_ready ? 0 : 9;
    endtask

    // Starts at the accept cycle; optionally withdraws and scrambles the granted requester's inputs.
    task automatic wait_res(input int drop_id, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            if (cycles == 0 && drop_id == 0) begin
                req0_valid = 1'b0; req0_dividend = $urandom; req0_divisor = $urandom;
            end
            if (cycles == 0 && drop_id == 1) begin
                req1_valid = 1'b0; req1_dividend = $urandom; req1_divisor = $urandom;
            end
            #1;
            cycles++;
            if (req0_ready || req1_ready) ready_bad++;
        end while (!res_valid && cycles < W + 4);
    endtask

    task automatic check_res(input string tag, input int cycles, input int exp_lat, input int id,
                             input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
        chk({tag, "_latency"}, cycles, exp_lat);
        chk({tag, "_valid"}, 32'(res_valid), 1);
        chk({tag, "_id"}, 32'(res_id), id);
        chk({tag, "_quot"}, res_quotient, q);
        chk({tag, "_rem"}, res_remainder, r);
        chk({tag, "_dbz"}, 32'(res_div_by_zero), 32'(dz));
        chk({tag, "_busy"}, 32'(busy), 1);
        @(negedge clk); #1;
        chk({tag, "_valid_once"}, 32'(res_valid), 0);
        chk({tag, "_quot_hold"}, res_quotient, q);
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    task automatic reset_pulse();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
    endtask

    initial begin
        // Reset values, with a request already asserted
        @(negedge clk);
        issue(0, 7, 1);
        #1;
        chk("rst_ready0", 32'(req0_ready), 0);
        chk("rst_ready1", 32'(req1_ready), 0);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_id", 32'(res_id), 0);
        chk("rst_quot", res_quotient, 0);
        chk("rst_rem", res_remainder, 0);
        chk("rst_dbz", 32'(res_div_by_zero), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk);
        req0_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Single requester, 1500/10
        issue(0, 1500, 10);
        wait_grant("a", g, n);
        chk("a_grant", g, 0);
        chk("a_wait", n, 0);
        wait_res(0, lat);
        check_res("a", lat, 33, 0, 150, 0, 1'b0);

        // Contention after reset: requester 0 first, then 1 the cycle after DONE
        reset_pulse();
        issue(0, 600, 4);
        issue(1, 1000, 7);
        wait_grant("b0", g, n);
        chk("b0_grant", g, 0);
        wait_res(0, lat);
        check_res("b0", lat, 33, 0, 150, 0, 1'b0);
        wait_grant("b1", g, n);
        chk("b1_grant", g, 1);
        chk("b1_wait", n, 0);
        wait_res(1, lat);
        check_res("b1", lat, 33, 1, 142, 6, 1'b0);

        // Both held valid over four results: alternate 0,1,0,1
        reset_pulse();
        issue(0, 100, 3);
        issue(1, 77, 7);
        for (int i = 0; i < 4; i++) begin
            wait_grant($sformatf("rr%0d", i), g, n);
            chk($sformatf("rr%0d_grant", i), g, i % 2);
            chk($sformatf("rr%0d_wait", i), n, 0);
            wait_res(-1, lat);
            check_res($sformatf("rr%0d", i), lat, 33, i % 2, (i % 2) ? 11 : 33, (i % 2) ? 0 : 1, 1'b0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Zero divisor, then a normal divide clears the flag
        @(negedge clk);
        issue(1, 500, 0);
        wait_grant("z", g, n);
        chk("z_grant", g, 1);
        wait_res(1, lat);
        check_res("z", lat, 1, 1, 0, 500, 1'b1);
        issue(0, 9, 2);
        wait_grant("zc", g, n);
        chk("zc_grant", g, 0);
        wait_res(0, lat);
        check_res("zc", lat, 33, 0, 4, 1, 1'b0);

        // Full-range operands
        issue(0, 32'hFFFF_FFFF, 1);
        wait_grant("m0", g, n);
        chk("m0_grant", g, 0);
        wait_res(0, lat);
        check_res("m0", lat, 33, 0, 32'hFFFF_FFFF, 0, 1'b0);
        issue(1, 5, 32'hFFFF_FFFF);
        wait_grant("m1", g, n);
        chk("m1_grant", g, 1);
        wait_res(1, lat);
        check_res("m1", lat, 33, 1, 0, 5, 1'b0);

        // Abort mid-division; pointer must return to favouring requester 0
        issue(0, 1234, 5);
        wait_grant("x", g, n);
        chk("x_grant", g, 0);
        @(negedge clk);
        req0_dividend = 4000;
        req0_divisor = 16;
        issue(1, 700, 7);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("x_ready0", 32'(req0_ready), 0);
        chk("x_ready1", 32'(req1_ready), 0);
        chk("x_valid", 32'(res_valid), 0);
        chk("x_id", 32'(res_id), 0);
        chk("x_quot", res_quotient, 0);
        chk("x_rem", res_remainder, 0);
        chk("x_dbz", 32'(res_div_by_zero), 0);
        chk("x_busy", 32'(busy), 0);
        @(negedge clk); #1;
        chk("x_hold_valid", 32'(res_valid), 0);
        rst = 1'b1;
        wait_grant("xr0", g, n);
        chk("xr0_grant", g, 0);
        chk("xr0_wait", n, 0);
        wait_res(0, lat);
        check_res("xr0", lat, 33, 0, 250, 0, 1'b0);
        wait_grant("xr1", g, n);
        chk("xr1_grant", g, 1);
        wait_res(1, lat);
        check_res("xr1", lat, 33, 1, 100, 0, 1'b0);

        chk("no_ready_while_busy", ready_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/metric_div_scheduler.md
METRIC_DIV_SCHEDULER -- requirements
Module: metric_div_scheduler

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; one clock domain only.
REQ-004 req0_valid  input  1  average-heart-rate divide request (heart_rate_sum / heart_rate_count).
REQ-005 req0_dividend, req0_divisor  input  WIDTH each  requester-0 operands, unsigned.
REQ-006 req0_ready  output  1  requester-0 accept strobe.
REQ-007 req1_valid  input  1  speed divide request (total_distance / time_elapsed).
REQ-008 req1_dividend, req1_divisor  input  WIDTH each  requester-1 operands, unsigned.
REQ-009 req1_ready  output  1  requester-1 accept strobe.
REQ-010 res_valid  output  1  one-cycle result strobe.
REQ-011 res_id  output  1  requester owning the current result (0 or 1).
REQ-012 res_quotient, res_remainder  output  WIDTH each  result of the last completed division.
REQ-013 res_div_by_zero  output  1  last completed division had divisor 0.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 Block SHALL time-share one restoring divider (one quotient bit per cycle) between the two requesters.
REQ-016 FSM states SHALL be IDLE, DIVIDE, DONE; no other states.
REQ-017 In IDLE with any reqN_valid high, reqN_ready SHALL go high combinationally for the granted requester only; operands captured at that clock edge (accept cycle); FSM leaves IDLE.
REQ-018 reqN_ready SHALL never be high outside IDLE and never high for both requesters in one cycle.
REQ-019 Single valid requester SHALL be granted immediately; when both valid, grant the requester not granted last (round-robin); after reset requester 0 has priority.
REQ-020 Requester SHALL hold valid and operands until ready; valid dropped before ready is a withdrawn request, no action.
REQ-021 Nonzero divisor: accept → DIVIDE for exactly WIDTH cycles → DONE one cycle → IDLE; res_valid high in cycle accept+WIDTH+1.
REQ-022 Zero divisor: accept → DONE next cycle (res_valid at accept+1); quotient 0, remainder = dividend, res_div_by_zero 1.
REQ-023 Nonzero divisor: res_div_by_zero 0; quotient = floor(dividend/divisor), remainder = dividend mod divisor, exact over full WIDTH range; partial remainder held WIDTH+1 bits internally.
REQ-024 res_valid SHALL be high only in DONE, exactly one cycle per accepted request.
REQ-025 res_quotient, res_remainder, res_id, res_div_by_zero SHALL update on entering DONE and hold until the next DONE.
REQ-026 No new grant in DONE cycle; earliest next accept is the cycle after DONE (throughput one result per WIDTH+2 cycles).
REQ-027 Operand input changes after accept SHALL not affect the division in progress.
REQ-028 Round-robin pointer SHALL update on every accept, including zero-divisor requests.

Reset
REQ-029 rst low SHALL immediately force IDLE, clear divider datapath, set round-robin pointer to favour requester 0.
REQ-030 Reset values: req0_ready 0 (combinational, low while rst low), req1_ready 0, res_valid 0, res_id 0, res_quotient 0, res_remainder 0, res_div_by_zero 0, busy 0.
REQ-031 Reset during DIVIDE/DONE SHALL abort the operation with no res_valid; first accept after rst high needs one clock edge with rst high.

Verification
REQ-032 req0 1500/10 alone → req0_ready one cycle, res_valid at accept+33, res_id 0, quotient 150, remainder 0.
REQ-033 req0 and req1 both valid after reset (req0 600/4, req1 1000/7) → req0 first: quotient 150 rem 0; req1 accepted cycle after DONE: quotient 142 rem 6, res_id 1.
REQ-034 Both held valid continuously over four results → grants alternate 0,1,0,1; never both ready same cycle.
REQ-035 req1 divisor 0, dividend 500 → res_valid at accept+1, quotient 0, remainder 500, res_div_by_zero 1; next nonzero request clears flag.
REQ-036 0xFFFFFFFF/1 and 5/0xFFFFFFFF → quotient 0xFFFFFFFF rem 0; quotient 0 rem 5.
REQ-037 rst low at accept+10 of a division → all outputs reset values immediately, no res_valid; after release, pending valid requester 0 granted first.
